uart_rx_param: RTL and testbench

//  Parametrised UART receiver for the sclk domain: sync + edge detect, FSM-sequenced deserialisation,
//  3-sample majority vote per bit, start-bit glitch rejection, stop-bit framing check, optional parity.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sampler.sv | 76 +++++++
 rtl/uart_rx_param.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, default timing constants and a counter-width helper
// shared by the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned DEF_CLK_DIV   = 434;
  localparam int unsigned DEF_DATA_BITS = 8;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises rs232_rx, detects the start edge, runs the baud counter and
// produces one 3-sample majority vote per bit period.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic rx_i,
  input  logic run_i,
  output logic edge_fall_o,
  output logic bit_tick_o,
  output logic bit_end_o,
  output logic bit_val_o
);

  localparam int unsigned       CNT_W  = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0]  MID_M1 = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  MID    = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0]  MID_P1 = CNT_W'(CLK_DIV / 2 + 1);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(CLK_DIV - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
  logic                   smp0_q, smp1_q;
  logic                   bit_val_q, bit_tick_q;
  logic                   synced;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign synced      = sync_q[SYNC_STAGES-1];
  assign edge_fall_o = prev_q & ~synced;
  assign bit_end_o   = run_i & (baud_cnt_q == LAST);
  assign bit_tick_o  = bit_tick_q;
  assign bit_val_o   = bit_val_q;

  // The edge cycle itself counts as bit time 0, so the vote window is not pushed late
  // by the detection cycle on top of the synchroniser delay.
  always_comb begin
    baud_cnt_d = '0;
    if (run_i || edge_fall_o) begin
      baud_cnt_d = (baud_cnt_q == LAST) ? '0 : baud_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sync_q     <= '1;
      prev_q     <= 1'b1;
      baud_cnt_q <= '0;
      smp0_q     <= 1'b1;
      smp1_q     <= 1'b1;
      bit_val_q  <= 1'b1;
      bit_tick_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
      prev_q     <= synced;
      baud_cnt_q <= baud_cnt_d;
      bit_tick_q <= 1'b0;
      if (run_i) begin
        if (baud_cnt_q == MID_M1) smp0_q <= synced;
        if (baud_cnt_q == MID)    smp1_q <= synced;
        if (baud_cnt_q == MID_P1) begin
          bit_val_q  <= maj3(smp0_q, smp1_q, synced);
          bit_tick_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver FSM, shifter and valid/ready holding register.
// Define UART_RX_PARITY_EN to expect and check one parity bit after the data bits.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 3,
  parameter bit          PARITY_ODD  = 1'b0
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_vld,
  input  logic                 rx_data_rdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rx_busy,
  output rx_state_t            rx_state
);

  localparam int unsigned      IDX_W     = cnt_width(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  logic edge_fall, bit_tick, bit_end, bit_val;

  rx_state_t            state_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 stop_idx_q;
  logic                 stop_bad_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 vld_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic final_stop, frame_bad, par_bad, done_good;

  uart_rx_sampler #(
    .CLK_DIV     (CLK_DIV),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .rx_i        (rs232_rx),
    .run_i       (state_q != IDLE),
    .edge_fall_o (edge_fall),
    .bit_tick_o  (bit_tick),
    .bit_end_o   (bit_end),
    .bit_val_o   (bit_val)
  );

`ifdef UART_RX_PARITY_EN
  logic par_acc_q;
  logic par_bad_q;
  logic parity_err_q;

  assign par_bad    = final_stop & par_bad_q;
  assign parity_err = parity_err_q;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      par_acc_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= par_bad;
      if (state_q == IDLE && edge_fall) begin
        par_acc_q <= 1'b0;
        par_bad_q <= 1'b0;
      end else if (state_q == DATA && bit_tick) begin
        par_acc_q <= par_acc_q ^ bit_val;
      end else if (state_q == PARITY && bit_tick) begin
        par_bad_q <= bit_val ^ par_acc_q ^ PARITY_ODD;
      end
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // The last stop bit is judged at its vote (MID+2), half a bit before its end.
  assign final_stop = (state_q == STOP) & bit_tick & (stop_idx_q == LAST_STOP);
  assign frame_bad  = final_stop & (stop_bad_q | ~bit_val);
  assign done_good  = final_stop & ~frame_bad & ~par_bad;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      stop_bad_q  <= 1'b0;
      shift_q     <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      overrun_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (edge_fall) begin
            state_q    <= START;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            stop_bad_q <= 1'b0;
          end
        end
        START: begin
          if (bit_tick && bit_val) state_q <= IDLE;
          else if (bit_end)        state_q <= DATA;
        end
        DATA: begin
          if (bit_tick) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_end) state_q <= STOP;
        end
`endif
        STOP: begin
          if (bit_tick) begin
            if (stop_idx_q == LAST_STOP) state_q <= IDLE;
            else stop_bad_q <= stop_bad_q | ~bit_val;
          end else if (bit_end) begin
            stop_idx_q <= stop_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A completion that coincides with an accept replaces the word without an overrun.
      if (done_good && (!vld_q || rx_data_rdy)) begin
        data_q <= shift_q;
        vld_q  <= 1'b1;
      end else if (done_good) begin
        overrun_q <= 1'b1;
      end else if (vld_q && rx_data_rdy) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign rx_data     = data_q;
  assign rx_data_vld = vld_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign rx_busy     = (state_q != IDLE);
  assign rx_state    = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames against a frame-level model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CLK_DIV   = 16;
  localparam int DATA_BITS = 8;
  localparam int W         = DATA_BITS;
  localparam bit PAR_ODD   = 1'b0;

  logic         sclk;
  logic         s_rst_n;
  logic         rs232_rx;
  logic         rx_data_rdy;
  logic [W-1:0] rx_data;
  logic         rx_data_vld, frame_err, parity_err, overrun, rx_busy;
  rx_state_t    rx_state;

  uart_rx_param #(
    .CLK_DIV     (CLK_DIV),
    .DATA_BITS   (DATA_BITS),
    .STOP_BITS   (1),
    .SYNC_STAGES (3),
    .PARITY_ODD  (PAR_ODD)
  ) dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .rs232_rx    (rs232_rx),
    .rx_data     (rx_data),
    .rx_data_vld (rx_data_vld),
    .rx_data_rdy (rx_data_rdy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .rx_busy     (rx_busy),
    .rx_state    (rx_state)
  );

  // clock / reset
  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  int           n_cmp = 0, n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] sent_q[$];
  int           n_ferr = 0, n_perr = 0, n_ovr = 0, n_vld_cyc = 0;
  bit           busy_seen = 1'b0;
  bit           rdy_rand = 1'b0;
  bit           rdy_level = 1'b0;

  // monitor: what the consumer side observes
  always @(negedge sclk) begin
    if (s_rst_n) begin
      if (rx_data_vld && rx_data_rdy) got_q.push_back(rx_data);
      if (rx_data_vld) n_vld_cyc++;
      if (frame_err)   n_ferr++;
      if (parity_err)  n_perr++;
      if (overrun)     n_ovr++;
      if (rx_busy)     busy_seen = 1'b1;
    end
  end

  // consumer ready driver, changes just after the active edge
  initial begin
    rx_data_rdy = 1'b0;
    forever begin
      @(posedge sclk);
      #1;
      rx_data_rdy = rdy_rand ? ($urandom_range(0, 31) == 0) : rdy_level;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int per, input bit spike);
    rs232_rx = b;
    if (!spike) begin
      repeat (per) @(negedge sclk);
    end else begin
      repeat (CLK_DIV / 2) @(negedge sclk);
      rs232_rx = ~b;
      @(negedge sclk);
      rs232_rx = b;
      repeat (per - CLK_DIV / 2 - 1) @(negedge sclk);
    end
  endtask

  // spike_idx selects a data bit that gets a one-clock inverted spike at mid-bit (-1: none)
  task automatic send_frame(input logic [W-1:0] d, input int per, input bit stop_ok,
                            input bit par_ok, input int spike_idx);
    logic pbit;
    pbit = (^d) ^ PAR_ODD ^ ~par_ok;
    send_bit(1'b0, per, 1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i], per, (i == spike_idx));
`ifdef UART_RX_PARITY_EN
    send_bit(pbit, per, 1'b0);
`else
    if (pbit === 1'bx) $error("FAIL parity_model: undefined parity bit");
`endif
    send_bit(stop_ok, per, 1'b0);
  endtask

  task automatic idle_bits(input int n);
    rs232_rx = 1'b1;
    repeat (n * CLK_DIV) @(negedge sclk);
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [W-1:0] b;
    int           ovr0, ferr0, p;
    bit           in_order;

    // reset state
    s_rst_n  = 1'b0;
    rs232_rx = 1'b1;
    repeat (3) @(negedge sclk);
    chk("rst_data", rx_data, 0);
    chk("rst_vld", rx_data_vld, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_state", 32'(rx_state), 32'(IDLE));
    s_rst_n = 1'b1;
    idle_bits(2);

    // basic frames with consumer always ready
    rdy_level = 1'b1;
    idle_bits(1);
    for (int i = 0; i < 8; i++) begin
      b = (i == 0) ? 8'hA5 : (i == 1) ? 8'h00 : (i == 2) ? 8'hFF : W'($urandom_range(0, 255));
      send_frame(b, CLK_DIV, 1'b1, 1'b1, -1);
      exp_q.push_back(b);
    end
    idle_bits(2);
    check_got("basic");
    chk("basic_vld_cycles", n_vld_cyc, 8);
    chk("basic_ferr", n_ferr, 0);
    chk("basic_ovr", n_ovr, 0);

    // back-to-back frames with consumer stalled
    rdy_level = 1'b0;
    idle_bits(1);
    send_frame(8'h11, CLK_DIV, 1'b1, 1'b1, -1);
    send_frame(8'h22, CLK_DIV, 1'b1, 1'b1, -1);
    send_frame(8'h33, CLK_DIV, 1'b1, 1'b1, -1);
    idle_bits(2);
    chk("ovr_vld", rx_data_vld, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_pulses", n_ovr, 2);
    rdy_level = 1'b1;
    @(negedge sclk);
    rdy_level = 1'b0;
    repeat (4) @(negedge sclk);
    exp_q.push_back(8'h11);
    check_got("ovr_accept");
    chk("ovr_vld_clear", rx_data_vld, 0);

    // stop-bit error, then a long break
    rdy_level = 1'b1;
    ferr0 = n_ferr;
    send_frame(8'h5A, CLK_DIV, 1'b0, 1'b1, -1);
    idle_bits(2);
    chk("stop_ferr", n_ferr - ferr0, 1);
    chk("stop_no_vld", got_q.size(), 0);
    rs232_rx = 1'b0;
    repeat (40 * CLK_DIV) @(negedge sclk);
    idle_bits(2);
    chk("break_ferr", n_ferr - ferr0, 2);
    send_frame(8'h3C, CLK_DIV, 1'b1, 1'b1, -1);
    idle_bits(2);
    exp_q.push_back(8'h3C);
    check_got("after_break");

    // short low glitch on an idle line
    busy_seen = 1'b0;
    ferr0 = n_ferr;
    rs232_rx = 1'b0;
    repeat (3) @(negedge sclk);
    rs232_rx = 1'b1;
    repeat (CLK_DIV - 3) @(negedge sclk);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_clear", rx_busy, 0);
    idle_bits(1);
    chk("glitch_no_vld", got_q.size(), 0);
    chk("glitch_no_ferr", n_ferr - ferr0, 0);

    // bit-rate skew and single-clock spikes
    send_frame(8'hC3, CLK_DIV - 1, 1'b1, 1'b1, -1);
    idle_bits(2);
    send_frame(8'hC3, CLK_DIV + 1, 1'b1, 1'b1, -1);
    idle_bits(2);
    send_frame(8'hC3, CLK_DIV, 1'b1, 1'b1, 2);
    idle_bits(1);
    send_frame(8'hC3, CLK_DIV, 1'b1, 1'b1, 7);
    idle_bits(2);
    repeat (4) exp_q.push_back(8'hC3);
    check_got("skew_spike");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, CLK_DIV, 1'b1, 1'b1, -1);
    idle_bits(2);
    exp_q.push_back(8'h07);
    check_got("parity_good");
    send_frame(8'h07, CLK_DIV, 1'b1, 1'b0, -1);
    idle_bits(2);
    chk("parity_err_pulse", n_perr, 1);
    chk("parity_no_vld", got_q.size(), 0);
`else
    chk("parity_tied", n_perr, 0);
`endif

    // random bytes, random consumer: every good frame is delivered or counted as overrun
    ovr0 = n_ovr;
    rdy_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = W'($urandom_range(0, 255));
      sent_q.push_back(b);
      send_frame(b, CLK_DIV, 1'b1, 1'b1, -1);
      idle_bits($urandom_range(0, 1));
    end
    rdy_rand  = 1'b0;
    rdy_level = 1'b1;
    idle_bits(3);
    chk("rand_total", got_q.size() + (n_ovr - ovr0), 10);
    chk("rand_first", got_q.size() > 0 ? got_q[0] : 8'hxx, sent_q[0]);
    p = 0;
    in_order = 1'b1;
    foreach (got_q[i]) begin
      while (p < sent_q.size() && sent_q[p] !== got_q[i]) p++;
      if (p == sent_q.size()) in_order = 1'b0;
      else p++;
    end
    chk("rand_order", in_order, 1);
    chk("rand_no_ferr", n_ferr - ferr0, 0);
    got_q.delete();

    // asynchronous reset in the middle of a frame with a word held
    rdy_level = 1'b0;
    idle_bits(1);
    send_frame(8'h99, CLK_DIV, 1'b1, 1'b1, -1);
    idle_bits(2);
    chk("hold_before_rst", rx_data_vld, 1);
    send_bit(1'b0, CLK_DIV, 1'b0);
    send_bit(1'b0, CLK_DIV, 1'b0);
    send_bit(1'b1, CLK_DIV, 1'b0);
    #3 s_rst_n = 1'b0;
    rs232_rx = 1'b1;
    @(negedge sclk);
    chk("midrst_vld", rx_data_vld, 0);
    chk("midrst_data", rx_data, 0);
    chk("midrst_busy", rx_busy, 0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    idle_bits(2);
    rdy_level = 1'b1;
    send_frame(8'h5F, CLK_DIV, 1'b1, 1'b1, -1);
    idle_bits(2);
    exp_q.push_back(8'h5F);
    check_got("after_midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
